demux32bit_stream: RTL and testbench



---
 rtl/demux32bit_stream.sv | 127 ++++++++++++
 tb/tb_demux32bit_stream.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/demux32bit_stream.sv
// Registered 1-to-2 valid/ready demultiplexer: each accepted word goes to channel 1 (select=0) or 2.
// Optional delivered-word counters on each channel are built when DEMUX_COUNT_EN is defined.
module demux32bit_stream #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             select,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [WIDTH-1:0] out2_data
`ifdef DEMUX_COUNT_EN
  ,
  output logic [15:0]      out1_count,
  output logic [15:0]      out2_count
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_e;

  chan_state_e      ch1_state_q, ch1_state_d;
  chan_state_e      ch2_state_q, ch2_state_d;
  logic [WIDTH-1:0] ch1_data_q, ch1_data_d;
  logic [WIDTH-1:0] ch2_data_q, ch2_data_d;

  logic in_hs, wr1, wr2, out1_hs, out2_hs;

  assign out1_valid = (ch1_state_q == FULL);
  assign out2_valid = (ch2_state_q == FULL);
  assign out1_data  = ch1_data_q;
  assign out2_data  = ch2_data_q;

  // A channel can take a word if it is empty or is being drained this cycle.
  assign in_ready = select ? (!out2_valid || out2_ready) : (!out1_valid || out1_ready);
  assign in_hs    = in_valid && in_ready;
  assign wr1      = in_hs && !select;
  assign wr2      = in_hs && select;
  assign out1_hs  = out1_valid && out1_ready;
  assign out2_hs  = out2_valid && out2_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch1_state_q <= EMPTY;
      ch2_state_q <= EMPTY;
      ch1_data_q  <= '0;
      ch2_data_q  <= '0;
    end else begin
      ch1_state_q <= ch1_state_d;
      ch2_state_q <= ch2_state_d;
      ch1_data_q  <= ch1_data_d;
      ch2_data_q  <= ch2_data_d;
    end
  end

  always_comb begin
    ch1_state_d = ch1_state_q;
    ch1_data_d  = ch1_data_q;
    unique case (ch1_state_q)
      EMPTY: begin
        if (wr1) begin
          ch1_state_d = FULL;
          ch1_data_d  = in_data;
        end
      end
      FULL: begin
        if (wr1) begin
          ch1_data_d = in_data;
        end else if (out1_hs) begin
          ch1_state_d = EMPTY;
        end
      end
      default: ch1_state_d = EMPTY;
    endcase
  end

  always_comb begin
    ch2_state_d = ch2_state_q;
    ch2_data_d  = ch2_data_q;
    unique case (ch2_state_q)
      EMPTY: begin
        if (wr2) begin
          ch2_state_d = FULL;
          ch2_data_d  = in_data;
        end
      end
      FULL: begin
        if (wr2) begin
          ch2_data_d = in_data;
        end else if (out2_hs) begin
          ch2_state_d = EMPTY;
        end
      end
      default: ch2_state_d = EMPTY;
    endcase
  end

`ifdef DEMUX_COUNT_EN
  logic [15:0] cnt1_q, cnt1_d;
  logic [15:0] cnt2_q, cnt2_d;

  // Counters wrap naturally at 16 bits.
  always_comb begin
    cnt1_d = out1_hs ? cnt1_q + 16'd1 : cnt1_q;
    cnt2_d = out2_hs ? cnt2_q + 16'd1 : cnt2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else begin
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
    end
  end

  assign out1_count = cnt1_q;
  assign out2_count = cnt2_q;
`endif

endmodule

// File: tb/tb_demux32bit_stream.sv
// Directed self-checking bench for demux32bit_stream; counter checks are built with DEMUX_COUNT_EN.
module tb_demux32bit_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        select;
  logic        out1_valid;
  logic        out1_ready;
  logic [31:0] out1_data;
  logic        out2_valid;
  logic        out2_ready;
  logic [31:0] out2_data;
`ifdef DEMUX_COUNT_EN
  logic [15:0] out1_count;
  logic [15:0] out2_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  demux32bit_stream #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .select     (select),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .out2_data  (out2_data)
`ifdef DEMUX_COUNT_EN
    ,
    .out1_count (out1_count),
    .out2_count (out2_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    select     = 1'b0;
    out1_ready = 1'b0;
    out2_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_out1_valid", {31'b0, out1_valid}, 32'd0);
    chk("rst_out2_valid", {31'b0, out2_valid}, 32'd0);
    chk("rst_out1_data", out1_data, 32'h0);
    chk("rst_out2_data", out2_data, 32'h0);
    chk("rst_in_ready_sel0", {31'b0, in_ready}, 32'd1);
    select = 1'b1;
    #1;
    chk("rst_in_ready_sel1", {31'b0, in_ready}, 32'd1);
    select = 1'b0;
`ifdef DEMUX_COUNT_EN
    chk("rst_out1_count", {16'b0, out1_count}, 32'd0);
    chk("rst_out2_count", {16'b0, out2_count}, 32'd0);
`endif
    #1;
    rst_n = 1'b1;

    // Single word to channel 1
    tick();
    in_valid   = 1'b1;
    in_data    = 32'hDEADBEEF;
    select     = 1'b0;
    out1_ready = 1'b1;
    #1;
    chk("single_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("single_out1_valid", {31'b0, out1_valid}, 32'd1);
    chk("single_out1_data", out1_data, 32'hDEADBEEF);
    chk("single_out2_valid", {31'b0, out2_valid}, 32'd0);
    tick();
    chk("drain_out1_valid", {31'b0, out1_valid}, 32'd0);
    chk("drain_out1_data_kept", out1_data, 32'hDEADBEEF);

    // Back-pressure on channel 2, then redirect to channel 1
    in_valid   = 1'b1;
    in_data    = 32'h00000001;
    select     = 1'b1;
    out2_ready = 1'b0;
    tick();
    chk("bp_out2_valid", {31'b0, out2_valid}, 32'd1);
    chk("bp_out2_data", out2_data, 32'h00000001);
    in_data = 32'h00000002;
    #1;
    chk("bp_in_ready_stall", {31'b0, in_ready}, 32'd0);
    tick();
    chk("bp_out2_data_hold", out2_data, 32'h00000001);
    chk("bp_out1_not_written", {31'b0, out1_valid}, 32'd0);
    select = 1'b0;
    #1;
    chk("bp_in_ready_sel0", {31'b0, in_ready}, 32'd1);
    tick();
    chk("bp_out1_valid", {31'b0, out1_valid}, 32'd1);
    chk("bp_out1_data", out1_data, 32'h00000002);
    chk("bp_out2_untouched", out2_data, 32'h00000001);
    chk("bp_out2_still_valid", {31'b0, out2_valid}, 32'd1);

    // Streaming 0..7 into channel 1 with its consumer always ready
    for (int i = 0; i < 8; i++) begin
      in_data = 32'(i);
      #1;
      chk($sformatf("stream_in_ready_%0d", i), {31'b0, in_ready}, 32'd1);
      tick();
      chk($sformatf("stream_out1_data_%0d", i), out1_data, 32'(i));
      chk($sformatf("stream_out1_valid_%0d", i), {31'b0, out1_valid}, 32'd1);
    end

    // Simultaneous drain and refill on channel 1, drain on channel 2
    in_data = 32'h0000000A;
    tick();
    chk("sim_out1_data_a", out1_data, 32'h0000000A);
    in_data    = 32'h0000000B;
    out2_ready = 1'b1;
    tick();
    chk("sim_out1_valid", {31'b0, out1_valid}, 32'd1);
    chk("sim_out1_data_b", out1_data, 32'h0000000B);
    chk("sim_out2_drained", {31'b0, out2_valid}, 32'd0);
    chk("sim_out2_data_kept", out2_data, 32'h00000001);

    // Fill channel 2 while channel 1 is stalled, then reset mid-cycle
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    select     = 1'b1;
    in_data    = 32'h0000000C;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_out1_valid", {31'b0, out1_valid}, 32'd1);
    chk("pre_rst_out2_valid", {31'b0, out2_valid}, 32'd1);
    chk("pre_rst_out2_data", out2_data, 32'h0000000C);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out1_valid", {31'b0, out1_valid}, 32'd0);
    chk("midrst_out2_valid", {31'b0, out2_valid}, 32'd0);
    chk("midrst_out1_data", out1_data, 32'h0);
    chk("midrst_out2_data", out2_data, 32'h0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("postrst_out1_valid", {31'b0, out1_valid}, 32'd0);
    chk("postrst_out2_valid", {31'b0, out2_valid}, 32'd0);

`ifdef DEMUX_COUNT_EN
    // First edge loads, each later edge delivers one word on channel 1
    chk("cnt_start1", {16'b0, out1_count}, 32'd0);
    in_valid   = 1'b1;
    select     = 1'b0;
    out1_ready = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      in_data = 32'(i);
      tick();
    end
    chk("cnt_out1_ffff", {16'b0, out1_count}, 32'h0000FFFF);
    tick();
    chk("cnt_out1_wrap", {16'b0, out1_count}, 32'h00000000);
    chk("cnt_out2_unchanged", {16'b0, out2_count}, 32'h00000000);
    in_valid = 1'b0;
    tick();
    chk("cnt_out1_after", {16'b0, out1_count}, 32'h00000001);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
